// File: rtl/cpu_sequencer.sv
// Instruction sequencer for cpu_top: accepts one instruction, runs it for one EXEC
// cycle, then holds the result on a valid/ready channel. Macro CPU_SEQ_PERF_EN adds a retired-instruction counter.
module cpu_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_REGS    = 8,
  parameter int ADDR_WIDTH  = $clog2(NUM_REGS),
  parameter int INSTR_WIDTH = DATA_WIDTH + 3*ADDR_WIDTH + 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic                   reg_write_enable,
  output logic [ADDR_WIDTH-1:0]  reg_write_addr,
  output logic [DATA_WIDTH-1:0]  reg_write_data,
  output logic [ADDR_WIDTH-1:0]  reg_read_addr1,
  output logic [ADDR_WIDTH-1:0]  reg_read_addr2,
  output logic [3:0]             alu_comm,
  output logic                   alu_mode,
  output logic                   alu_cin,
  output logic                   b_source_sel,
  output logic [DATA_WIDTH-1:0]  alu_b_imm,
  input  logic [DATA_WIDTH-1:0]  alu_result,
  input  logic                   alu_cout,
  input  logic                   alu_nbo,
  input  logic                   alu_ngo,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_WIDTH-1:0]  res_data,
  output logic                   res_cout,
  output logic [15:0]            instr_count
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  typedef struct packed {
    logic                  kind;
    logic [3:0]            comm;
    logic                  mode;
    logic                  cin;
    logic                  bsel;
    logic                  we;
    logic [ADDR_WIDTH-1:0] dst;
    logic [ADDR_WIDTH-1:0] src1;
    logic [ADDR_WIDTH-1:0] src2;
    logic [DATA_WIDTH-1:0] imm;
  } instr_t;

  instr_t ins;
  assign ins = instr;

  state_t                state_q, state_d;
  logic                  kind_q, kind_d;
  logic [3:0]            comm_q, comm_d;
  logic                  mode_q, mode_d;
  logic                  cin_q, cin_d;
  logic                  bsel_q, bsel_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH-1:0] src1_q, src1_d;
  logic [ADDR_WIDTH-1:0] src2_q, src2_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_cout_q, res_cout_d;
  logic                  wr_pend_q, wr_pend_d;

  // Flag outputs of the ALU are not consumed by the sequencer.
  logic unused_flags;
  assign unused_flags = alu_nbo ^ alu_ngo;

`ifdef CPU_SEQ_PERF_EN
  logic [15:0] count_q, count_d;
`endif

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    comm_d     = comm_q;
    mode_d     = mode_q;
    cin_d      = cin_q;
    bsel_d     = bsel_q;
    we_d       = we_q;
    dst_d      = dst_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    imm_d      = imm_q;
    res_data_d = res_data_q;
    res_cout_d = res_cout_q;
    wr_pend_d  = 1'b0;
`ifdef CPU_SEQ_PERF_EN
    count_d    = count_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          kind_d  = ins.kind;
          comm_d  = ins.comm;
          mode_d  = ins.mode;
          cin_d   = ins.cin;
          // LOADI routes its immediate through the B-operand mux.
          bsel_d  = ins.bsel | ins.kind;
          we_d    = ins.we;
          dst_d   = ins.dst;
          src1_d  = ins.src1;
          src2_d  = ins.src2;
          imm_d   = ins.imm;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_data_d = kind_q ? imm_q : alu_result;
        res_cout_d = kind_q ? 1'b0 : alu_cout;
        wr_pend_d  = we_q | kind_q;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (res_ready) begin
          state_d = S_IDLE;
`ifdef CPU_SEQ_PERF_EN
          count_d = count_q + 16'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      kind_q     <= 1'b0;
      comm_q     <= '0;
      mode_q     <= 1'b0;
      cin_q      <= 1'b0;
      bsel_q     <= 1'b0;
      we_q       <= 1'b0;
      dst_q      <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      imm_q      <= '0;
      res_data_q <= '0;
      res_cout_q <= 1'b0;
      wr_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      comm_q     <= comm_d;
      mode_q     <= mode_d;
      cin_q      <= cin_d;
      bsel_q     <= bsel_d;
      we_q       <= we_d;
      dst_q      <= dst_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      imm_q      <= imm_d;
      res_data_q <= res_data_d;
      res_cout_q <= res_cout_d;
      wr_pend_q  <= wr_pend_d;
    end
  end

`ifdef CPU_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) count_q <= 16'd0;
    else       count_q <= count_d;
  end
  assign instr_count = count_q;
`else
  assign instr_count = 16'd0;
`endif

  assign instr_ready      = (state_q == S_IDLE);
  assign res_valid        = (state_q == S_RESP);
  // wr_pend_q is only ever set for the single cycle following EXEC.
  assign reg_write_enable = wr_pend_q;
  assign reg_write_addr   = dst_q;
  assign reg_write_data   = res_data_q;
  assign reg_read_addr1   = src1_q;
  assign reg_read_addr2   = src2_q;
  assign alu_comm         = comm_q;
  assign alu_mode         = mode_q;
  assign alu_cin          = cin_q;
  assign b_source_sel     = bsel_q;
  assign alu_b_imm        = imm_q;
  assign res_data         = res_data_q;
  assign res_cout         = res_cout_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: emulates cpu_top (register file + 74181-style ALU) and
// checks each instruction against an instruction-level reference model.
module tb_cpu_sequencer;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int IW = DW + 3*AW + 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr;
  logic          reg_write_enable;
  logic [AW-1:0] reg_write_addr;
  logic [DW-1:0] reg_write_data;
  logic [AW-1:0] reg_read_addr1, reg_read_addr2;
  logic [3:0]    alu_comm;
  logic          alu_mode, alu_cin, b_source_sel;
  logic [DW-1:0] alu_b_imm;
  logic [DW-1:0] alu_result;
  logic          alu_cout;
  logic          res_valid, res_ready;
  logic [DW-1:0] res_data;
  logic          res_cout;
  logic [15:0]   instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .reg_write_enable(reg_write_enable), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data),
    .reg_read_addr1(reg_read_addr1), .reg_read_addr2(reg_read_addr2),
    .alu_comm(alu_comm), .alu_mode(alu_mode), .alu_cin(alu_cin),
    .b_source_sel(b_source_sel), .alu_b_imm(alu_b_imm),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .alu_nbo(1'b0), .alu_ngo(1'b0),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_cout(res_cout),
    .instr_count(instr_count)
  );

  // 74181-style ALU, active-high data; carry-in of 0 adds one.
  function automatic logic [16:0] alu_ref(input logic [3:0] s, input logic m,
                                          input logic cin, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [15:0] x, y, f;
    if (m) begin
      case (s)
        4'd0:  f = ~a;        4'd1:  f = ~(a | b);
        4'd2:  f = ~a & b;    4'd3:  f = 16'h0000;
        4'd4:  f = ~(a & b);  4'd5:  f = ~b;
        4'd6:  f = a ^ b;     4'd7:  f = a & ~b;
        4'd8:  f = ~a | b;    4'd9:  f = ~(a ^ b);
        4'd10: f = b;         4'd11: f = a & b;
        4'd12: f = 16'hFFFF;  4'd13: f = a | ~b;
        4'd14: f = a | b;     default: f = a;
      endcase
      return {1'b0, f};
    end
    case (s)
      4'd0:  begin x = a;          y = 16'h0000; end
      4'd1:  begin x = a | b;      y = 16'h0000; end
      4'd2:  begin x = a | ~b;     y = 16'h0000; end
      4'd3:  begin x = 16'h0000;   y = 16'hFFFF; end
      4'd4:  begin x = a;          y = a & ~b;   end
      4'd5:  begin x = a | b;      y = a & ~b;   end
      4'd6:  begin x = a;          y = ~b;       end
      4'd7:  begin x = a & ~b;     y = 16'hFFFF; end
      4'd8:  begin x = a;          y = a & b;    end
      4'd9:  begin x = a;          y = b;        end
      4'd10: begin x = a | ~b;     y = a & b;    end
      4'd11: begin x = a & b;      y = 16'hFFFF; end
      4'd12: begin x = a;          y = a;        end
      4'd13: begin x = a | b;      y = a;        end
      4'd14: begin x = a | ~b;     y = a;        end
      default: begin x = a;        y = 16'hFFFF; end
    endcase
    return {1'b0, x} + {1'b0, y} + {16'd0, ~cin};
  endfunction

  // cpu_top stand-in: register file written by the DUT, combinational ALU.
  logic [DW-1:0] regs [8];
  int wr_pulses = 0;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (reg_write_enable) begin
      regs[reg_write_addr] <= reg_write_data;
      wr_pulses <= wr_pulses + 1;
    end
  end

  logic [16:0] env_r;
  always_comb begin
    env_r = alu_ref(alu_comm, alu_mode, alu_cin, regs[reg_read_addr1],
                    b_source_sel ? alu_b_imm : regs[reg_read_addr2]);
    alu_result = env_r[15:0];
    alu_cout   = env_r[16];
  end

  // Instruction-level reference state.
  logic [DW-1:0] mregs [8];
  logic [15:0]   exp_count;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt_view();
`ifdef CPU_SEQ_PERF_EN
    return exp_count;
`else
    return 16'd0;
`endif
  endfunction

  task automatic run_instr(input logic k, input logic [3:0] comm, input logic m,
                           input logic c, input logic bs, input logic we,
                           input logic [2:0] d, input logic [2:0] s1,
                           input logic [2:0] s2, input logic [15:0] imm,
                           input int stall, output logic [15:0] got);
    logic [16:0] r;
    logic [15:0] exp_d;
    logic        exp_c, exp_we;
    int          wp0;
    r      = alu_ref(comm, m, c, mregs[s1], bs ? imm : mregs[s2]);
    exp_d  = k ? imm : r[15:0];
    exp_c  = k ? 1'b0 : r[16];
    exp_we = we | k;
    chk("idle_ready", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr       = {k, comm, m, c, bs, we, d, s1, s2, imm};
    wp0         = wr_pulses;
    tick();
    instr_valid = 1'($urandom());
    instr       = IW'({$urandom(), $urandom()});
    chk("exec_ready", 32'(instr_ready), 32'd0);
    chk("exec_valid", 32'(res_valid), 32'd0);
    chk("exec_wen", 32'(reg_write_enable), 32'd0);
    chk("exec_rd1", 32'(reg_read_addr1), 32'(s1));
    chk("exec_rd2", 32'(reg_read_addr2), 32'(s2));
    chk("exec_ctrl", 32'({alu_comm, alu_mode, alu_cin, b_source_sel}),
        32'({comm, m, c, bs | k}));
    chk("exec_imm", 32'(alu_b_imm), 32'(imm));
    res_ready = (stall == 0);
    tick();
    chk("resp_valid", 32'(res_valid), 32'd1);
    chk("resp_data", 32'(res_data), 32'(exp_d));
    chk("resp_cout", 32'(res_cout), 32'(exp_c));
    chk("resp_wen", 32'(reg_write_enable), 32'(exp_we));
    chk("resp_waddr", 32'(reg_write_addr), 32'(d));
    chk("resp_wdata", 32'(reg_write_data), 32'(exp_d));
    chk("resp_ready", 32'(instr_ready), 32'd0);
    got = res_data;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", 32'(res_valid), 32'd1);
      chk("stall_data", 32'({res_cout, res_data}), 32'({exp_c, exp_d}));
      chk("stall_wen", 32'(reg_write_enable), 32'd0);
      chk("stall_ready", 32'(instr_ready), 32'd0);
      if (i == stall - 1) res_ready = 1'b1;
    end
    tick();
    instr_valid = 1'b0;
    res_ready   = 1'($urandom());
    chk("done_valid", 32'(res_valid), 32'd0);
    chk("done_ready", 32'(instr_ready), 32'd1);
    chk("done_wen", 32'(reg_write_enable), 32'd0);
    chk("done_hold", 32'({alu_comm, alu_mode, alu_cin, b_source_sel}),
        32'({comm, m, c, bs | k}));
    chk("write_pulses", 32'(wr_pulses - wp0), 32'(exp_we));
    if (exp_we) mregs[d] = exp_d;
    exp_count = exp_count + 16'd1;
    chk("instr_count", 32'(instr_count), 32'(exp_cnt_view()));
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] imm;
    logic        k;
    reset       = 1'b1;
    instr_valid = 1'b1;
    instr       = {1'b1, 4'd0, 4'd0, 3'd6, 3'd0, 3'd0, 16'hAAAA};
    res_ready   = 1'b0;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    exp_count = '0;
    tick();
    tick();
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_wen", 32'(reg_write_enable), 32'd0);
    chk("rst_cout", 32'(res_cout), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_data", 32'({res_data, reg_write_data, alu_b_imm}), 32'd0);
    chk("rst_addr", 32'({reg_write_addr, reg_read_addr1, reg_read_addr2}), 32'd0);
    chk("rst_ctrl", 32'({alu_comm, alu_mode, alu_cin, b_source_sel}), 32'd0);
    reset       = 1'b0;
    instr_valid = 1'b0;
    tick();
    chk("post_rst_idle", 32'(instr_ready), 32'd1);

    run_instr(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0, 3'd0, 16'h1234, 0, got);
    run_instr(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0, 3'd0, 16'h5678, 0, got);
    run_instr(1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd2, 3'd3, 16'h0000, 0, got);
    chk("plan_add", 32'(got), 32'h68AD);
    run_instr(1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 3'd2, 3'd3, 16'h0000, 0, got);
    chk("plan_sub", 32'(got), 32'hBBBB);
    run_instr(1'b0, 4'b1011, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 3'd2, 3'd0, 16'h00FF, 0, got);
    chk("plan_and", 32'(got), 32'h0034);
    run_instr(1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd2, 3'd3, 16'h0000, 0, got);
    run_instr(1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 3'd4, 3'd3, 16'h0000, 0, got);
    chk("raw_dep", 32'(got), 32'h68AD + 32'h5678 + 32'd1);
    run_instr(1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd5, 3'd2, 16'h0000, 5, got);

    // Abort a LOADI r6=AAAA by resetting during its EXEC cycle.
    begin
      int wp0;
      wp0         = wr_pulses;
      instr_valid = 1'b1;
      instr       = {1'b1, 4'd0, 4'd0, 3'd6, 3'd0, 3'd0, 16'hAAAA};
      tick();
      instr_valid = 1'b0;
      chk("abort_in_exec", 32'(instr_ready), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) mregs[i] = '0;
      exp_count = '0;
      chk("abort_ready", 32'(instr_ready), 32'd1);
      chk("abort_valid", 32'(res_valid), 32'd0);
      tick();
      chk("abort_valid2", 32'(res_valid), 32'd0);
      chk("abort_nowrite", 32'(wr_pulses - wp0), 32'd0);
      chk("abort_count", 32'(instr_count), 32'd0);
    end
    run_instr(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd6, 3'd0, 16'h0000, 0, got);
    chk("abort_r6", 32'(got), 32'h0000);

    for (int n = 0; n < 40; n++) begin
      k   = ($urandom_range(0, 3) == 0);
      imm = 16'($urandom());
      run_instr(k, 4'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()),
                1'($urandom()), 3'($urandom()), 3'($urandom()), 3'($urandom()),
                imm, $urandom_range(0, 3), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
